huffman_stream_packer: RTL and testbench

Parametrised Huffman stream encoder that follows the code-table generator in the compression path. It loads a symbol→(length, code) table from the generator's symbol/length/code output. It then encodes a valid/ready symbol stream into MSB-first packed words of OUT_W bits, with backpressure, end-of-stream flush and zero padding. It generalises symbol width, maximum code length and output word width, and adds streaming encode and bit packing.

---
 rtl/huffman_stream_packer.sv | 194 +++++++++++++++++++
 tb/tb_huffman_stream_packer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/huffman_stream_packer.sv
// rtl/huffman_stream_packer.sv - table-driven Huffman encoder packing codes MSB-first into OUT_W-bit words
module huffman_stream_packer #(
    parameter int SYM_W   = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int OUT_W   = 32,
    parameter int CNT_W   = $clog2(OUT_W + 1)
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               tbl_wr,
    input  logic [SYM_W-1:0]   tbl_sym,
    input  logic [LEN_W-1:0]   tbl_len,
    input  logic [MAX_LEN-1:0] tbl_code,
    input  logic               enc_start,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [SYM_W-1:0]   sym_in,
    input  logic               sym_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [CNT_W-1:0]   out_bits,
    output logic               out_last,
    output logic               err_nocode,
    output logic               err_tbl,
    output logic               busy
);
    localparam int ACC_W  = OUT_W + MAX_LEN;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int DEPTH  = 1 << SYM_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ENCODE = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic [LEN_W-1:0]   len_tbl_q  [DEPTH];
    logic [MAX_LEN-1:0] code_tbl_q [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_bits_q, out_bits_d;
    logic              out_last_q, out_last_d;
    logic              err_nocode_q, err_nocode_d;
    logic              err_tbl_q, err_tbl_d;

    logic               tbl_we;
    logic [LEN_W-1:0]   cur_len;
    logic [MAX_LEN-1:0] cur_code;
    logic [MAX_LEN-1:0] len_mask;
    logic [ACC_W-1:0]   code_ext;
    logic [FILL_W-1:0]  shamt;
    logic               ready_w;
    logic               accept;
    logic               out_free;
    logic               hs_last;

    // Table lookup, accumulator append and word-emission decisions
    always_comb begin
        cur_len  = len_tbl_q[sym_in];
        cur_code = code_tbl_q[sym_in];
        // Mask off any stray bits above the code length; len==MAX_LEN wraps to all ones
        len_mask = ({{(MAX_LEN-1){1'b0}}, 1'b1} << cur_len) - {{(MAX_LEN-1){1'b0}}, 1'b1};
        code_ext = {{OUT_W{1'b0}}, cur_code & len_mask};
        shamt    = FILL_W'(ACC_W) - fill_q - FILL_W'(cur_len);
        ready_w  = (state_q == S_ENCODE) && (fill_q < FILL_W'(OUT_W));
        accept   = ready_w && sym_valid;
        out_free = !out_valid_q || out_ready;
        hs_last  = out_valid_q && out_ready && out_last_q;

        state_d      = state_q;
        fill_d       = fill_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_bits_d   = out_bits_q;
        out_last_d   = out_last_q;
        err_nocode_d = 1'b0;
        err_tbl_d    = 1'b0;
        tbl_we       = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (tbl_wr) begin
                    if (tbl_len > LEN_W'(MAX_LEN)) begin
                        err_tbl_d = 1'b1;
                    end else begin
                        tbl_we = 1'b1;
                    end
                end
                if (enc_start) begin
                    state_d = S_ENCODE;
                end
            end
            S_ENCODE: begin
                // sym_ready requires fill < OUT_W, so accept and emit are exclusive
                if (accept) begin
                    acc_d  = acc_q | (code_ext << shamt);
                    fill_d = fill_q + FILL_W'(cur_len);
                    if (cur_len == '0) begin
                        err_nocode_d = 1'b1;
                    end
                    if (sym_last) begin
                        state_d = S_FLUSH;
                    end
                end else if (out_free && (fill_q >= FILL_W'(OUT_W))) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q[ACC_W-1 -: OUT_W];
                    out_bits_d  = CNT_W'(OUT_W);
                    out_last_d  = 1'b0;
                    acc_d       = acc_q << OUT_W;
                    fill_d      = fill_q - FILL_W'(OUT_W);
                end
            end
            S_FLUSH: begin
                // Once the last word is loaded it sits until its handshake, so no second last
                if (hs_last) begin
                    state_d = S_IDLE;
                end else if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q[ACC_W-1 -: OUT_W];
                    if (fill_q >= FILL_W'(OUT_W)) begin
                        out_bits_d = CNT_W'(OUT_W);
                        out_last_d = (fill_q == FILL_W'(OUT_W));
                        acc_d      = acc_q << OUT_W;
                        fill_d     = fill_q - FILL_W'(OUT_W);
                    end else begin
                        out_bits_d = CNT_W'(fill_q);
                        out_last_d = 1'b1;
                        acc_d      = '0;
                        fill_d     = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control, accumulator and output register state
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fill_q       <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_bits_q   <= '0;
            out_last_q   <= 1'b0;
            err_nocode_q <= 1'b0;
            err_tbl_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_bits_q   <= out_bits_d;
            out_last_q   <= out_last_d;
            err_nocode_q <= err_nocode_d;
            err_tbl_q    <= err_tbl_d;
        end
    end

    // Code table; reset invalidates every entry by zeroing its length
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                len_tbl_q[i] <= '0;
            end
        end else if (tbl_we) begin
            len_tbl_q[tbl_sym]  <= tbl_len;
            code_tbl_q[tbl_sym] <= tbl_code;
        end
    end

    assign sym_ready  = ready_w;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_bits   = out_bits_q;
    assign out_last   = out_last_q;
    assign err_nocode = err_nocode_q;
    assign err_tbl    = err_tbl_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_huffman_stream_packer.sv
// tb/tb_huffman_stream_packer.sv - directed self-checking bench for huffman_stream_packer
module tb_huffman_stream_packer;
    localparam int SYM_W   = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int OUT_W   = 8;
    localparam int CNT_W   = 4;

    logic               clock = 1'b0;
    logic               rst = 1'b1;
    logic               tbl_wr = 1'b0;
    logic [SYM_W-1:0]   tbl_sym = '0;
    logic [LEN_W-1:0]   tbl_len = '0;
    logic [MAX_LEN-1:0] tbl_code = '0;
    logic               enc_start = 1'b0;
    logic               sym_valid = 1'b0;
    logic               sym_ready;
    logic [SYM_W-1:0]   sym_in = '0;
    logic               sym_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_W-1:0]   out_data;
    logic [CNT_W-1:0]   out_bits;
    logic               out_last;
    logic               err_nocode;
    logic               err_tbl;
    logic               busy;

    int total = 0;
    int passes = 0;

    huffman_stream_packer #(
        .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .rst(rst),
        .tbl_wr(tbl_wr), .tbl_sym(tbl_sym), .tbl_len(tbl_len), .tbl_code(tbl_code),
        .enc_start(enc_start),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_in(sym_in), .sym_last(sym_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bits(out_bits), .out_last(out_last),
        .err_nocode(err_nocode), .err_tbl(err_tbl), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] s, input logic [4:0] l, input logic [15:0] c, output logic e);
        tbl_wr = 1'b1; tbl_sym = s; tbl_len = l; tbl_code = c;
        step();
        tbl_wr = 1'b0;
        e = err_tbl;
    endtask

    task automatic start(input string tag);
        enc_start = 1'b1;
        step();
        enc_start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ready"}, sym_ready, 1);
    endtask

    task automatic send(input string tag, input logic [7:0] s, input logic l, output logic e);
        int n;
        n = 0;
        sym_valid = 1'b1; sym_in = s; sym_last = l;
        while (!sym_ready && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_accept"}, sym_ready, 1);
        step();
        sym_valid = 1'b0; sym_last = 1'b0;
        e = err_nocode;
    endtask

    task automatic wait_word(input string tag, input logic [7:0] d, input logic [3:0] b, input logic l);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_bits"}, out_bits, b);
        chk({tag, "_last"}, out_last, l);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic e;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_bits", out_bits, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_nocode", err_nocode, 0);
        chk("rst_err_tbl", err_tbl, 0);
        rst = 1'b0;

        wr(8'h41, 5'd2, 16'b10, e);
        chk("wr41_err", e, 0);
        wr(8'h42, 5'd3, 16'b110, e);

        // Aligned stream; 0x43 written in the same cycle as enc_start
        tbl_wr = 1'b1; tbl_sym = 8'h43; tbl_len = 5'd1; tbl_code = 16'h0;
        start("al_start");
        tbl_wr = 1'b0;
        send("al0", 8'h41, 1'b0, e);
        send("al1", 8'h42, 1'b0, e);
        send("al2", 8'h43, 1'b0, e);
        chk("al2_noerr", e, 0);
        send("al3", 8'h41, 1'b1, e);
        wait_word("al_w", 8'hB2, 4'd8, 1'b1);
        chk("al_busy_after", busy, 0);

        // Partial flush with backpressure on the first word
        start("pf_start");
        send("pf0", 8'h41, 1'b0, e);
        send("pf1", 8'h41, 1'b0, e);
        send("pf2", 8'h41, 1'b0, e);
        send("pf3", 8'h42, 1'b0, e);
        chk("pf_ready_full", sym_ready, 0);
        send("pf4", 8'h42, 1'b1, e);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 8'hAB);
            chk("bp_hold_last", out_last, 0);
            step();
        end
        wait_word("pf_w0", 8'hAB, 4'd8, 1'b0);
        chk("pf_b2b_valid", out_valid, 1);
        wait_word("pf_w1", 8'h60, 4'd4, 1'b1);
        chk("pf_busy_after", busy, 0);

        // Missing code as the only symbol
        start("mc_start");
        send("mc0", 8'h50, 1'b1, e);
        chk("mc_err_pulse", e, 1);
        step();
        chk("mc_err_once", err_nocode, 0);
        wait_word("mc_w", 8'h00, 4'd0, 1'b1);
        chk("mc_busy_after", busy, 0);

        // Table errors: oversize length dropped, write during ENCODE ignored
        wr(8'h44, 5'd17, 16'h1, e);
        chk("te_err_tbl", e, 1);
        step();
        chk("te_err_tbl_once", err_tbl, 0);
        start("te_start");
        wr(8'h41, 5'd1, 16'h1, e);
        chk("te_enc_wr_noerr", e, 0);
        send("te0", 8'h44, 1'b0, e);
        chk("te_44_nocode", e, 1);
        send("te1", 8'h41, 1'b1, e);
        chk("te_41_code", e, 0);
        wait_word("te_w", 8'h80, 4'd2, 1'b1);

        // Reset mid-stream clears table and state
        start("rs_start");
        send("rs0", 8'h41, 1'b0, e);
        send("rs1", 8'h42, 1'b0, e);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_busy", busy, 0);
        chk("rs_ready", sym_ready, 0);
        chk("rs_valid", out_valid, 0);
        chk("rs_data", out_data, 0);
        chk("rs_bits", out_bits, 0);
        start("rs_restart");
        send("rs2", 8'h41, 1'b1, e);
        chk("rs_nocode", e, 1);
        wait_word("rs_w", 8'h00, 4'd0, 1'b1);
        chk("rs_busy_after", busy, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
